// File: rtl/finger_pkg.sv
// Shared definitions for the finger judge: FSM encoding, finger count and
// the combo level at which a hit starts earning a bonus point.
// Optional feature macro: FINGER_COMBO_EN (combo counter and score bonus).
package finger_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HIT  = 2'd2,
    MISS = 2'd3
  } state_t;

  localparam int N_FINGERS      = 4;
  localparam int COMBO_BONUS_TH = 4;

  // Increment an 8-bit counter, sticking at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/finger_judge_if.sv
// Beat/verdict bus between the game sequencer (master) and the judge (slave).
// Handshake: pattern is sampled only in a cycle where pattern_vld=1; there is
// no back-pressure, each pattern_vld strobe is one beat. hit/miss are 1-cycle
// verdict pulses (never both), C and score hold their value between verdicts.
// Optional feature macro: FINGER_COMBO_EN (adds combo).
interface finger_judge_if #(
  parameter int SCORE_W = 8
);
  import finger_pkg::*;

  logic [N_FINGERS-1:0] pattern;
  logic                 pattern_vld;
  logic [SCORE_W-1:0]   score;
  logic                 C;
  logic                 hit;
  logic                 miss;
`ifdef FINGER_COMBO_EN
  logic [7:0]           combo;

  modport master (output pattern, pattern_vld, input score, C, hit, miss, combo);
  modport slave  (input pattern, pattern_vld, output score, C, hit, miss, combo);
`else
  modport master (output pattern, pattern_vld, input score, C, hit, miss);
  modport slave  (input pattern, pattern_vld, output score, C, hit, miss);
`endif

endinterface

// File: rtl/finger_judge_btn_debounce.sv
// One-bit button conditioner: 2-FF synchronizer followed by a stability
// counter. The level output follows the synced input only after it has
// disagreed for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic res,
  input  logic btn,
  output logic db
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (sync2 != db) begin
      if (cnt == CNT_LAST) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/finger_judge.sv
// Finger judge: debounces the four finger buttons, judges presses against
// the target pattern of each beat and keeps the running score and correct flag.
// Optional feature macro: FINGER_COMBO_EN (consecutive-hit combo, bonus point).
module finger_judge
  import finger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HIT_WINDOW      = 16,
  parameter int SCORE_W         = 8
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 clr,
  input  logic [N_FINGERS-1:0] btn,
  output logic [N_FINGERS-1:0] btn_db,
  output state_t               dbg_state,
  finger_judge_if.slave        bus
);
  localparam int WIN_W = $clog2(HIT_WINDOW);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(HIT_WINDOW - 1);

  state_t               state_q, state_d;
  logic [N_FINGERS-1:0] target_q, target_d;
  logic [N_FINGERS-1:0] acc_q, acc_d, acc_now;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [N_FINGERS-1:0] btn_db_q, press;
  logic                 hit_d, miss_d;
  logic [SCORE_W-1:0]   score_q;
  logic [SCORE_W:0]     inc, sum;
  logic                 c_q, hit_q, miss_q;

  for (genvar i = 0; i < N_FINGERS; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk (clk),
      .res (res),
      .btn (btn[i]),
      .db  (btn_db[i])
    );
  end

  assign press = btn_db & ~btn_db_q;

  // Delayed debounced levels, used to find press (rising) edges.
  always_ff @(posedge clk or negedge res) begin
    if (!res) btn_db_q <= '0;
    else      btn_db_q <= btn_db;
  end

  // FSM state and beat context registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= IDLE;
      target_q <= '0;
      acc_q    <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      acc_q    <= acc_d;
      win_q    <= win_d;
    end
  end

  // Next state and verdict; a new pattern_vld always opens a fresh window.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    acc_d    = acc_q;
    win_d    = win_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    acc_now  = acc_q | press;
    case (state_q)
      IDLE: ;
      WAIT: begin
        acc_d = acc_now;
        if (win_q != '0) win_d = win_q - 1'b1;
        if (bus.pattern_vld) begin
          miss_d = 1'b1;
        end else if ((acc_now & ~target_q) != '0) begin
          miss_d  = 1'b1;
          state_d = MISS;
        end else if (target_q != '0 && acc_now == target_q) begin
          hit_d   = 1'b1;
          state_d = HIT;
        end else if (win_q == '0) begin
          if (target_q == '0) begin
            hit_d   = 1'b1;
            state_d = HIT;
          end else begin
            miss_d  = 1'b1;
            state_d = MISS;
          end
        end
      end
      HIT, MISS: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (bus.pattern_vld) begin
      target_d = bus.pattern;
      acc_d    = '0;
      win_d    = WIN_LOAD;
      state_d  = WAIT;
    end
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
    end
  end

`ifdef FINGER_COMBO_EN
  logic [7:0] combo_q;

  assign inc = (combo_q >= 8'(COMBO_BONUS_TH)) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1);

  // Consecutive-hit counter; any miss or clear breaks the run.
  always_ff @(posedge clk or negedge res) begin
    if (!res)                combo_q <= '0;
    else if (clr || miss_d)  combo_q <= '0;
    else if (hit_d)          combo_q <= sat_inc8(combo_q);
  end

  assign bus.combo = combo_q;
`else
  assign inc = (SCORE_W+1)'(1);
`endif

  assign sum = {1'b0, score_q} + inc;

  // Registered verdict outputs and saturating score.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      score_q <= '0;
      c_q     <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else if (clr) begin
      score_q <= '0;
      c_q     <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
      if (hit_d) begin
        c_q     <= 1'b1;
        score_q <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
      end else if (miss_d) begin
        c_q <= 1'b0;
      end
    end
  end

  assign bus.score = score_q;
  assign bus.C     = c_q;
  assign bus.hit   = hit_q;
  assign bus.miss  = miss_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_finger_judge.sv
// Bench for finger_judge (DEBOUNCE_CYCLES=2, HIT_WINDOW=8). Verdicts are
// predicted into a queue when each beat is driven and compared when the
// DUT pulses hit or miss. Honours FINGER_COMBO_EN when defined.
module tb_finger_judge;
  import finger_pkg::*;

  localparam int DEB = 2;
  localparam int WIN = 8;
  localparam int SW  = 8;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] btn = 4'b0;
  logic [3:0] btn_db;
  state_t     dbg_state;

  finger_judge_if #(.SCORE_W(SW)) bus ();

  finger_judge #(
    .DEBOUNCE_CYCLES (DEB),
    .HIT_WINDOW      (WIN),
    .SCORE_W         (SW)
  ) dut (
    .clk       (clk),
    .res       (res),
    .clr       (clr),
    .btn       (btn),
    .btn_db    (btn_db),
    .dbg_state (dbg_state),
    .bus       (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_vec  = 0;
  int          n_fail = 0;
  int          exp_score = 0;
  int          exp_combo = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model one verdict and queue {hit, miss, C, score} for the monitor.
  task automatic expect_verdict(input bit h);
    int step;
    if (h) begin
      step = (exp_combo >= COMBO_BONUS_TH) ? 2 : 1;
`ifndef FINGER_COMBO_EN
      step = 1;
`endif
      exp_score = (exp_score + step > 255) ? 255 : exp_score + step;
      exp_combo = (exp_combo == 255) ? 255 : exp_combo + 1;
    end else begin
      exp_combo = 0;
    end
    exp_q.push_back({h, ~h, h, 8'(exp_score)});
  endtask

  // Compare every verdict pulse against the head of the expected queue.
  always @(negedge clk) begin
    if (res && (bus.hit || bus.miss)) begin
      if (exp_q.size() == 0) check("unexpected_verdict", 32'(bus.hit | bus.miss), 32'd0);
      else check("verdict", {21'd0, bus.hit, bus.miss, bus.C, bus.score}, {21'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] pat);
    bus.pattern     = pat;
    bus.pattern_vld = 1'b1;
    tick();
    bus.pattern_vld = 1'b0;
  endtask

  task automatic wait_verdict(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (bus.hit || bus.miss) return;
    end
    check("verdict_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_game();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_score = 0;
    exp_combo = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   n;
    logic seen;
    bus.pattern     = '0;
    bus.pattern_vld = 1'b0;
    repeat (3) tick();
    check("rst_score", 32'(bus.score), 32'd0);
    check("rst_C", 32'(bus.C), 32'd0);
    check("rst_hitmiss", 32'({bus.hit, bus.miss}), 32'd0);
    check("rst_btn_db", 32'(btn_db), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    res = 1'b1;
    tick();

    // 1-cycle glitch must be filtered, a held press appears 2+DEB cycles later.
    btn = 4'b0010;
    tick();
    btn = 4'b0000;
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen |= btn_db[1];
    end
    check("glitch_filtered", 32'(seen), 32'd0);
    btn = 4'b0010;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (btn_db[1]) break;
    end
    check("db_latency", 32'(n), 32'(2 + DEB));
    tick();
    btn = 4'b0000;
    repeat (8) tick();
    check("db_release", 32'(btn_db), 32'd0);

    // Two-finger target completed by two staggered presses.
    expect_verdict(1'b1);
    beat(4'b0110);
    btn = 4'b0010;
    tick();
    btn = 4'b0110;
    wait_verdict(n);
    check("hit_latency", 32'(n), 32'(DEB + 3));
    check("hit_pulse", 32'(bus.hit), 32'd1);
    check("hit_C", 32'(bus.C), 32'd1);
    check("hit_score", 32'(bus.score), 32'd1);
    tick();
    check("hit_one_cycle", 32'(bus.hit), 32'd0);
    check("C_held", 32'(bus.C), 32'd1);
    btn = 4'b0000;
    repeat (8) tick();

    // Wrong finger, then no press at all.
    expect_verdict(1'b0);
    beat(4'b0110);
    btn = 4'b1000;
    wait_verdict(n);
    check("wrong_latency", 32'(n), 32'(DEB + 3));
    check("wrong_C", 32'(bus.C), 32'd0);
    check("wrong_score", 32'(bus.score), 32'd1);
    btn = 4'b0000;
    repeat (8) tick();
    expect_verdict(1'b0);
    beat(4'b0110);
    wait_verdict(n);
    check("late_latency", 32'(n), 32'(WIN));

    // Rest beat, then a new beat arriving while still waiting.
    expect_verdict(1'b1);
    beat(4'b0000);
    wait_verdict(n);
    check("rest_latency", 32'(n), 32'(WIN));
    repeat (2) tick();
    expect_verdict(1'b0);
    beat(4'b0001);
    repeat (2) tick();
    expect_verdict(1'b1);
    beat(4'b0000);
    check("revld_miss", 32'(bus.miss), 32'd1);
    check("revld_state", 32'(dbg_state), 32'(WAIT));
    wait_verdict(n);
    check("revld_window", 32'(n), 32'(WIN));

    // Five consecutive hits from a fresh game, then async reset mid-run.
    clear_game();
    check("clr_score", 32'(bus.score), 32'd0);
    for (int i = 0; i < 5; i++) begin
      expect_verdict(1'b1);
      beat(4'b0000);
      wait_verdict(n);
    end
    check("five_hits_score", 32'(bus.score), 32'(exp_score));
`ifdef FINGER_COMBO_EN
    check("combo5", 32'(bus.combo), 32'd5);
    expect_verdict(1'b0);
    beat(4'b0001);
    wait_verdict(n);
    check("combo_miss", 32'(bus.combo), 32'd0);
`endif
    @(negedge clk);
    #2;
    res = 1'b0;
    #1;
    check("arst_score", 32'(bus.score), 32'd0);
    check("arst_C", 32'(bus.C), 32'd0);
    check("arst_hitmiss", 32'({bus.hit, bus.miss}), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    exp_score = 0;
    exp_combo = 0;
    tick();
    res = 1'b1;
    repeat (4) tick();
    check("arst_btn_db", 32'(btn_db), 32'd0);

    // Run the score up to its ceiling and one hit beyond.
    for (int i = 0; i < 300 && exp_score < 255; i++) begin
      expect_verdict(1'b1);
      beat(4'b0000);
      wait_verdict(n);
    end
    check("score_max", 32'(bus.score), 32'd255);
    expect_verdict(1'b1);
    beat(4'b0000);
    wait_verdict(n);
    check("score_sat", 32'(bus.score), 32'd255);

    tick();
    clear_game();
    check("clr_end_score", 32'(bus.score), 32'd0);
    check("clr_end_C", 32'(bus.C), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
